// File: rtl/c499_key_loader.sv
// Bit-serial key loader for the logic-locked c499 core.
// Parity-checked shadow load, armed key hold, fail counting and lockout.
module c499_key_loader #(
  parameter int KEY_W    = 37,
  parameter int MUX_W    = 4,
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             zeroize,
  input  logic             key_bit,
  input  logic             key_vld,
  output logic             key_rdy,
  output logic [KEY_W-1:0] key_x,
  output logic [MUX_W-1:0] key_p,
  output logic             armed,
  output logic             busy,
  output logic             fail,
  output logic             lockout,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int N    = KEY_W + MUX_W + 1;
  localparam int BC_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ARMED,
    S_FAIL,
    S_LOCK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Shift-in shadow: first accepted bit ends at r_sh[0], parity at r_sh[N-1].
  logic [N-1:0]     r_sh;
  logic [BC_W-1:0]  r_cnt;
  logic [KEY_W-1:0] r_key_x;
  logic [MUX_W-1:0] r_key_p;
  logic [CNT_W-1:0] r_fail_cnt;

  logic             w_clr;
  logic             w_accept;
  logic             w_commit;
  logic             w_bad;
  logic             w_last;
  logic             w_ok;
  logic [CNT_W-1:0] w_fail_inc;

  assign w_ok       = ~^r_sh;
  assign w_last     = (r_cnt == BC_W'(N - 1));
  assign w_fail_inc = r_fail_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_bad       = 1'b0;
    unique case (r_state)
      S_LOCK: begin
        w_state_nxt = S_LOCK;
      end
      S_LOAD: begin
        if (zeroize) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (key_vld) begin
          w_accept = 1'b1;
          if (w_last) w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (zeroize) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (w_ok) begin
          w_state_nxt = S_ARMED;
          w_commit    = 1'b1;
        end else begin
          w_bad       = 1'b1;
          w_state_nxt = (w_fail_inc == CNT_W'(MAX_FAIL)) ? S_LOCK : S_FAIL;
        end
      end
      default: begin
        if (zeroize) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (start) begin
          w_state_nxt = S_LOAD;
          w_clr       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_key_x    <= '0;
      r_key_p    <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_sh    <= '0;
        r_cnt   <= '0;
        r_key_x <= '0;
        r_key_p <= '0;
      end else if (w_accept) begin
        r_sh  <= {key_bit, r_sh[N-1:1]};
        r_cnt <= r_cnt + BC_W'(1);
      end
      if (w_commit) begin
        r_key_x    <= r_sh[KEY_W-1:0];
        r_key_p    <= r_sh[N-2:KEY_W];
        r_fail_cnt <= '0;
      end
      if (w_bad) r_fail_cnt <= w_fail_inc;
    end
  end

  assign key_x    = r_key_x;
  assign key_p    = r_key_p;
  assign fail_cnt = r_fail_cnt;
  assign key_rdy  = (r_state == S_LOAD);
  assign busy     = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign armed    = (r_state == S_ARMED);
  assign fail     = (r_state == S_FAIL);
  assign lockout  = (r_state == S_LOCK);

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader.
// Each task drives one scenario and checks outputs inline.
module tb_c499_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_vld = 1'b0;
  logic        key_rdy;
  logic [36:0] key_x;
  logic [3:0]  key_p;
  logic        armed;
  logic        busy;
  logic        fail;
  logic        lockout;
  logic [3:0]  fail_cnt;

  int errors = 0;
  int checks = 0;

  c499_key_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .zeroize(zeroize),
    .key_bit(key_bit), .key_vld(key_vld), .key_rdy(key_rdy),
    .key_x(key_x), .key_p(key_p), .armed(armed), .busy(busy),
    .fail(fail), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Streams nbits of {par,p,x} LSB first, counting real handshakes.
  task automatic send_key(input logic [36:0] x, input logic [3:0] p,
                          input logic par, input int nbits,
                          input bit gappy, input bit poke_start);
    logic [41:0] s;
    int n;
    int cyc;
    bit tog;
    bit acc;
    s = {par, p, x};
    n = 0;
    cyc = 0;
    tog = 1'b1;
    while (n < nbits && cyc < 2000) begin
      key_bit = s[n];
      key_vld = gappy ? (tog && ($urandom_range(0, 3) != 0)) : 1'b1;
      start   = poke_start && (n == 10);
      tog     = !tog;
      acc     = key_vld && key_rdy;
      tick();
      if (acc) n++;
      cyc++;
    end
    key_vld = 1'b0;
    start   = 1'b0;
    checks++;
    if (n != nbits) begin
      errors++;
      $display("FAIL send_timeout accepted=%0d want=%0d", n, nbits);
    end
  endtask

  task automatic do_load(input logic [36:0] x, input logic [3:0] p,
                         input logic par);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_key(x, p, par, 42, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (key_x !== 37'h0 || key_p !== 4'h0) begin
      errors++;
      $display("FAIL reset_key got=%h/%h want=0/0", key_x, key_p);
    end
    checks++;
    if ({armed, busy, fail, lockout, key_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000",
               {armed, busy, fail, lockout, key_rdy});
    end
    checks++;
    if (fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_fail_cnt got=%0d want=0", fail_cnt);
    end
  endtask

  task automatic test_good_load;
    checks++;
    if (key_rdy !== 1'b0) begin
      errors++;
      $display("FAIL good_rdy_pre got=%b want=0", key_rdy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (key_rdy !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL good_rdy_rise got=%b%b want=11", key_rdy, busy);
    end
    send_key(37'h1, 4'b1010, 1'b1, 42, 1'b0, 1'b0);
    checks++;
    if (key_rdy !== 1'b0 || busy !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL good_check got rdy=%b busy=%b armed=%b want 0 1 0",
               key_rdy, busy, armed);
    end
    tick();
    checks++;
    if (armed !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_armed got armed=%b busy=%b want 1 0", armed, busy);
    end
    checks++;
    if (key_x !== 37'h1 || key_p !== 4'b1010 || fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL good_key got=%h/%b/%0d want=1/1010/0",
               key_x, key_p, fail_cnt);
    end
  endtask

  task automatic test_bad_parity;
    do_load(37'h1, 4'b1010, 1'b0);
    checks++;
    if (fail !== 1'b1 || fail_cnt !== 4'd1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL bad_flags got fail=%b cnt=%0d armed=%b want 1 1 0",
               fail, fail_cnt, armed);
    end
    checks++;
    if (key_x !== 37'h0 || key_p !== 4'h0) begin
      errors++;
      $display("FAIL bad_key got=%h/%h want=0/0", key_x, key_p);
    end
    do_load(37'h1, 4'b1010, 1'b1);
    checks++;
    if (armed !== 1'b1 || fail_cnt !== 4'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL bad_recover got armed=%b cnt=%0d fail=%b want 1 0 0",
               armed, fail_cnt, fail);
    end
  endtask

  task automatic test_lockout;
    do_load(37'h1, 4'b1010, 1'b0);
    do_load(37'h1, 4'b1010, 1'b0);
    checks++;
    if (fail_cnt !== 4'd2 || fail !== 1'b1 || lockout !== 1'b0) begin
      errors++;
      $display("FAIL lock_pre got cnt=%0d fail=%b lock=%b want 2 1 0",
               fail_cnt, fail, lockout);
    end
    do_load(37'h1, 4'b1010, 1'b0);
    checks++;
    if (lockout !== 1'b1 || fail_cnt !== 4'd3 || fail !== 1'b0) begin
      errors++;
      $display("FAIL lock_enter got lock=%b cnt=%0d fail=%b want 1 3 0",
               lockout, fail_cnt, fail);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    tick();
    checks++;
    if (lockout !== 1'b1 || key_rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_hold got lock=%b rdy=%b busy=%b want 1 0 0",
               lockout, key_rdy, busy);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (lockout !== 1'b0 || fail_cnt !== 4'd0 || key_x !== 37'h0) begin
      errors++;
      $display("FAIL lock_rst got lock=%b cnt=%0d x=%h want 0 0 0",
               lockout, fail_cnt, key_x);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({armed, busy, fail, lockout, key_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL lock_idle got=%b want=00000",
               {armed, busy, fail, lockout, key_rdy});
    end
  endtask

  task automatic test_zeroize;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_key({37{1'b1}}, 4'hF, 1'b1, 20, 1'b0, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    checks++;
    if (key_rdy !== 1'b0 || busy !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL zero_mid got rdy=%b busy=%b armed=%b want 0 0 0",
               key_rdy, busy, armed);
    end
    // zeroize on the final bit: the bit is dropped, no CHECK follows
    start = 1'b1;
    tick();
    start = 1'b0;
    send_key(37'h1, 4'b1010, 1'b1, 41, 1'b0, 1'b0);
    key_bit = 1'b1;
    key_vld = 1'b1;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    key_vld = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_rdy !== 1'b0) begin
      errors++;
      $display("FAIL zero_last got busy=%b rdy=%b want 0 0", busy, key_rdy);
    end
    tick();
    checks++;
    if (armed !== 1'b0 || fail !== 1'b0 || fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL zero_nochk got armed=%b fail=%b cnt=%0d want 0 0 0",
               armed, fail, fail_cnt);
    end
    do_load(37'h10_0000_0003, 4'b0001, 1'b0);
    checks++;
    if (armed !== 1'b1 || key_x !== 37'h10_0000_0003 || key_p !== 4'b0001) begin
      errors++;
      $display("FAIL zero_reload got armed=%b x=%h p=%b want 1 1000000003 0001",
               armed, key_x, key_p);
    end
  endtask

  task automatic test_gaps;
    int extra;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_key(37'h0A_5A5A_5A5A, 4'b0110, 1'b0, 42, 1'b1, 1'b1);
    checks++;
    if (key_rdy !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_done got rdy=%b busy=%b want 0 1", key_rdy, busy);
    end
    extra = 0;
    key_vld = 1'b1;
    key_bit = 1'b1;
    repeat (3) begin
      if (key_vld && key_rdy) extra++;
      tick();
    end
    key_vld = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL gap_extra_hs got=%0d want=0", extra);
    end
    checks++;
    if (armed !== 1'b1 || key_x !== 37'h0A_5A5A_5A5A || key_p !== 4'b0110) begin
      errors++;
      $display("FAIL gap_key got armed=%b x=%h p=%b want 1 0a5a5a5a5a 0110",
               armed, key_x, key_p);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_parity();
    test_lockout();
    test_zeroize();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
